// File: rtl/mfp_7seg_scan_pkg.sv
// Shared constants for the 7-segment scanner: default geometry, segment codes
// and a width helper that never returns zero.
package mfp_7seg_scan_pkg;

  localparam int DEF_N_DIGITS  = 8;
  localparam int DEF_TICK_DIV  = 12500;
  localparam int DEF_BLANK_CYC = 64;

  // Active-low cathode pattern with every segment off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Bit width needed to hold 0..n-1, with a floor of one bit.
  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mfp_7seg_hexdec.sv
// Combinational hex nibble to active-low 7-segment decoder, bit order {CA..CG}.
module mfp_7seg_hexdec
  import mfp_7seg_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  // Map each nibble to its cathode pattern (0 = segment lit).
  always_comb begin
    // NOTE: assigning a default before the case keeps this purely combinational (no latch).
    seg_n = SEG_BLANK;
    case (hex)
      4'h0: seg_n = 7'b0000001;
      4'h1: seg_n = 7'b1001111;
      4'h2: seg_n = 7'b0010010;
      4'h3: seg_n = 7'b0000110;
      4'h4: seg_n = 7'b1001100;
      4'h5: seg_n = 7'b0100100;
      4'h6: seg_n = 7'b0100000;
      4'h7: seg_n = 7'b0001111;
      4'h8: seg_n = 7'b0000000;
      4'h9: seg_n = 7'b0000100;
      4'hA: seg_n = 7'b0001000;
      4'hB: seg_n = 7'b1100000;
      4'hC: seg_n = 7'b0110001;
      4'hD: seg_n = 7'b1000010;
      4'hE: seg_n = 7'b0110000;
      4'hF: seg_n = 7'b0111000;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/mfp_7seg_scan.sv
// Time-multiplexed scanner for N common-anode 7-segment digits.
// New display content is staged in pending registers and only committed at the
// last cycle of a frame, so a frame is never drawn with mixed old/new data.
// Optional build macro MFP_7SEG_DIM_EN adds a 4-bit brightness input and PWM dimming.
module mfp_7seg_scan
  import mfp_7seg_scan_pkg::*;
#(
  parameter int N_DIGITS  = DEF_N_DIGITS,
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int BLANK_CYC = DEF_BLANK_CYC
)(
  input  logic                  SI_ClkIn,
  input  logic                  SI_Reset,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   en_in,
  input  logic [N_DIGITS-1:0]   dp_in,
`ifdef MFP_7SEG_DIM_EN
  input  logic [3:0]            brightness,
`endif
  output logic [N_DIGITS-1:0]   IO_7SEGEN_N,
  output logic [6:0]            IO_7SEG_N,
  output logic                  IO_7SEG_DP_N,
  output logic                  frame_start
);

  localparam int CNT_W = width_min1(TICK_DIV);
  localparam int IDX_W = width_min1(N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*N_DIGITS-1:0]   pend_digits_q, pend_digits_d, act_digits_q, act_digits_d;
  logic [N_DIGITS-1:0]     pend_en_q, pend_en_d, act_en_q, act_en_d;
  logic [N_DIGITS-1:0]     pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [N_DIGITS-1:0]     an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    fs_q, fs_d;
  logic                    slot_wrap, frame_end, lit, pwm_ok;
  logic [3:0]              cur_hex;
  logic [6:0]              cur_seg;

`ifdef MFP_7SEG_DIM_EN
  logic [3:0] pend_bright_q, pend_bright_d, act_bright_q, act_bright_d;
  logic [3:0] pwm_q, pwm_d;

  // Free-running PWM phase; digit may light only while phase < brightness+1.
  always_comb begin
    pwm_d  = pwm_q + 4'd1;
    pwm_ok = ({1'b0, pwm_q} < ({1'b0, act_bright_q} + 5'd1));
  end
`else
  // Without dimming the digit is lit for the whole unblanked window.
  always_comb begin
    pwm_ok = 1'b1;
  end
`endif

  // Slot counter and digit index; a frame ends on the last cycle of the last slot.
  always_comb begin
    slot_wrap = (cnt_q == CNT_LAST);
    frame_end = slot_wrap && (idx_q == IDX_LAST);
    cnt_d     = slot_wrap ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  // Stage loads into pending; commit to active only at the frame boundary.
  always_comb begin
    pend_digits_d = pend_digits_q;
    pend_en_d     = pend_en_q;
    pend_dp_d     = pend_dp_q;
    pend_valid_d  = pend_valid_q;
    act_digits_d  = act_digits_q;
    act_en_d      = act_en_q;
    act_dp_d      = act_dp_q;
`ifdef MFP_7SEG_DIM_EN
    pend_bright_d = pend_bright_q;
    act_bright_d  = act_bright_q;
`endif
    if (load) begin
      pend_digits_d = digits_in;
      pend_en_d     = en_in;
      pend_dp_d     = dp_in;
      pend_valid_d  = 1'b1;
`ifdef MFP_7SEG_DIM_EN
      pend_bright_d = brightness;
`endif
    end
    if (frame_end) begin
      // A load on the boundary cycle itself goes straight to active.
      if (load) begin
        act_digits_d = digits_in;
        act_en_d     = en_in;
        act_dp_d     = dp_in;
        pend_valid_d = 1'b0;
`ifdef MFP_7SEG_DIM_EN
        act_bright_d = brightness;
`endif
      end else if (pend_valid_q) begin
        act_digits_d = pend_digits_q;
        act_en_d     = pend_en_q;
        act_dp_d     = pend_dp_q;
        pend_valid_d = 1'b0;
`ifdef MFP_7SEG_DIM_EN
        act_bright_d = pend_bright_q;
`endif
      end
    end
  end

  mfp_7seg_hexdec u_hexdec (
    .hex   (cur_hex),
    .seg_n (cur_seg)
  );

  // Next pin state from the current slot; cathodes and DP blank whenever the anode is off.
  always_comb begin
    cur_hex     = act_digits_q[4*idx_q +: 4];
    lit         = act_en_q[idx_q] && (cnt_q >= BLANK_END) && pwm_ok;
    an_d        = '1;
    an_d[idx_q] = ~lit;
    seg_d       = lit ? cur_seg : SEG_BLANK;
    dp_d        = lit ? ~act_dp_q[idx_q] : 1'b1;
    fs_d        = (cnt_q == '0) && (idx_q == '0);
  end

  // State and output registers with synchronous reset; reset aborts the scan at once.
  always_ff @(posedge SI_ClkIn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (SI_Reset) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      pend_digits_q <= '0;
      pend_en_q     <= '0;
      pend_dp_q     <= '0;
      pend_valid_q  <= 1'b0;
      act_digits_q  <= '0;
      act_en_q      <= '0;
      act_dp_q      <= '0;
      an_q          <= '1;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      fs_q          <= 1'b0;
`ifdef MFP_7SEG_DIM_EN
      pend_bright_q <= '0;
      act_bright_q  <= '0;
      pwm_q         <= '0;
`endif
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      pend_digits_q <= pend_digits_d;
      pend_en_q     <= pend_en_d;
      pend_dp_q     <= pend_dp_d;
      pend_valid_q  <= pend_valid_d;
      act_digits_q  <= act_digits_d;
      act_en_q      <= act_en_d;
      act_dp_q      <= act_dp_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      fs_q          <= fs_d;
`ifdef MFP_7SEG_DIM_EN
      pend_bright_q <= pend_bright_d;
      act_bright_q  <= act_bright_d;
      pwm_q         <= pwm_d;
`endif
    end
  end

  assign IO_7SEGEN_N  = an_q;
  assign IO_7SEG_N    = seg_q;
  assign IO_7SEG_DP_N = dp_q;
  assign frame_start  = fs_q;

endmodule

// File: tb/tb_mfp_7seg_scan.sv
// Bench for mfp_7seg_scan with 4 digits, 8-clock slots, 2-clock blanking (32-clock frame).
// Position bookkeeping: k counts rising edges since reset release; after k edges
// the outputs show scan position k-1 and the internal state sits at position k.
module tb_mfp_7seg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] digits;
  logic [3:0]  en;
  logic [3:0]  dp;
`ifdef MFP_7SEG_DIM_EN
  logic [3:0]  brightness = 4'hF;
`endif
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dpn;
  logic        fs;

  int checks   = 0;
  int failures = 0;
  int k        = 0;

  always #5 clk = ~clk;

  mfp_7seg_scan #(
    .N_DIGITS  (4),
    .TICK_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .SI_ClkIn     (clk),
    .SI_Reset     (rst),
    .load         (load),
    .digits_in    (digits),
    .en_in        (en),
    .dp_in        (dp),
`ifdef MFP_7SEG_DIM_EN
    .brightness   (brightness),
`endif
    .IO_7SEGEN_N  (an),
    .IO_7SEG_N    (seg),
    .IO_7SEG_DP_N (dpn),
    .frame_start  (fs)
  );

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  en;
    logic [3:0]  dp;
    int          slot;
    int          cnt;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dpn;
    logic        fs;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [15:0] d, input logic [3:0] e, input logic [3:0] p,
                              input int s, input int c, input logic [3:0] a,
                              input logic [6:0] sg, input logic dn, input logic f);
    vec_t v;
    v.digits = d; v.en = e; v.dp = p; v.slot = s; v.cnt = c;
    v.an = a; v.seg = sg; v.dpn = dn; v.fs = f;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [3:0] ea, input logic [6:0] es,
                           input logic ed, input logic ef);
    check({name, ".an"},  an,  ea);
    check({name, ".seg"}, seg, es);
    check({name, ".dp"},  dpn, ed);
    check({name, ".fs"},  fs,  ef);
  endtask

  task automatic tick();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic advance_to(input int target);
    while (k < target) tick();
  endtask

  // Outputs show position p after edge p+1.
  task automatic observe(input int p);
    advance_to(p + 1);
  endtask

  // Load is sampled while the state sits at position q (returned).
  task automatic do_load(input logic [15:0] d, input logic [3:0] e, input logic [3:0] p,
                         output int q);
    digits = d; en = e; dp = p; load = 1'b1;
    q = k;
    tick();
    load = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q, f, g, h, t0, t1;

    // Stimulus table: each entry is loaded, then checked in the following frame.
    add(16'h3210, 4'hF, 4'b0100, 0, 0, 4'hF, 7'h7F, 1'b1, 1'b1);
    add(16'h3210, 4'hF, 4'b0100, 0, 1, 4'hF, 7'h7F, 1'b1, 1'b0);
    add(16'h3210, 4'hF, 4'b0100, 0, 2, 4'hE, 7'h01, 1'b1, 1'b0);
    add(16'h3210, 4'hF, 4'b0100, 0, 7, 4'hE, 7'h01, 1'b1, 1'b0);
    add(16'h3210, 4'hF, 4'b0100, 1, 2, 4'hD, 7'h4F, 1'b1, 1'b0);
    add(16'h3210, 4'hF, 4'b0100, 2, 1, 4'hF, 7'h7F, 1'b1, 1'b0);
    add(16'h3210, 4'hF, 4'b0100, 2, 3, 4'hB, 7'h12, 1'b0, 1'b0);
    add(16'h3210, 4'hF, 4'b0100, 3, 5, 4'h7, 7'h06, 1'b1, 1'b0);
    add(16'h3210, 4'b1010, 4'b0100, 0, 4, 4'hF, 7'h7F, 1'b1, 1'b0);
    add(16'h3210, 4'b1010, 4'b0100, 1, 4, 4'hD, 7'h4F, 1'b1, 1'b0);
    add(16'h3210, 4'b1010, 4'b0100, 2, 4, 4'hF, 7'h7F, 1'b1, 1'b0);
    add(16'h3210, 4'b1010, 4'b0100, 3, 4, 4'h7, 7'h06, 1'b1, 1'b0);
    add(16'hFC9B, 4'hF, 4'b1000, 0, 6, 4'hE, 7'h60, 1'b1, 1'b0);
    add(16'hFC9B, 4'hF, 4'b1000, 1, 2, 4'hD, 7'h04, 1'b1, 1'b0);
    add(16'hFC9B, 4'hF, 4'b1000, 2, 7, 4'hB, 7'h31, 1'b1, 1'b0);
    add(16'hFC9B, 4'hF, 4'b1000, 3, 3, 4'h7, 7'h38, 1'b0, 1'b0);
    add(16'h7654, 4'hF, 4'b0000, 0, 3, 4'hE, 7'h4C, 1'b1, 1'b0);
    add(16'h7654, 4'hF, 4'b0000, 1, 6, 4'hD, 7'h24, 1'b1, 1'b0);
    add(16'h7654, 4'hF, 4'b0000, 2, 2, 4'hB, 7'h20, 1'b1, 1'b0);
    add(16'h7654, 4'hF, 4'b0000, 3, 7, 4'h7, 7'h0F, 1'b1, 1'b0);
    add(16'hEDA8, 4'hF, 4'b0000, 0, 2, 4'hE, 7'h00, 1'b1, 1'b0);
    add(16'hEDA8, 4'hF, 4'b0000, 1, 5, 4'hD, 7'h08, 1'b1, 1'b0);
    add(16'hEDA8, 4'hF, 4'b0000, 2, 3, 4'hB, 7'h42, 1'b1, 1'b0);
    add(16'hEDA8, 4'hF, 4'b0000, 3, 7, 4'h7, 7'h30, 1'b1, 1'b0);

    // Reset held for 3 cycles.
    rst = 1'b1; load = 1'b0; digits = '0; en = '0; dp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_out("reset", 4'hF, 7'h7F, 1'b1, 1'b0);
    rst = 1'b0;
    k = 0;

    // First frame after reset: frame_start on position 0, nothing lit before any load.
    tick();
    check_out("idle0", 4'hF, 7'h7F, 1'b1, 1'b1);
    for (int p = 1; p < 32; p++) begin
      tick();
      check($sformatf("idle%0d.an", p), an, 4'hF);
      check($sformatf("idle%0d.fs", p), fs, 1'b0);
    end

    // Table-driven vectors.
    foreach (vecs[i]) begin
      do_load(vecs[i].digits, vecs[i].en, vecs[i].dp, q);
      f = q / 32 + 1;
      observe(f * 32 + vecs[i].slot * 8 + vecs[i].cnt);
      check_out($sformatf("vec%0d", i), vecs[i].an, vecs[i].seg, vecs[i].dpn, vecs[i].fs);
    end

    // frame_start period.
    t0 = -1; t1 = -1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (fs) begin
        if (t0 < 0) t0 = k;
        else if (t1 < 0) t1 = k;
      end
    end
    check("fs_period", t1 - t0, 32);

    // Load mid-slot 1: current frame keeps old content, next frame shows all 'A'.
    do_load(16'h3210, 4'hF, 4'b0100, q);
    f = q / 32 + 1;
    advance_to(f * 32 + 8 + 3);
    do_load(16'hAAAA, 4'hF, 4'b0000, q);
    observe(f * 32 + 2 * 8 + 4);
    check_out("notear_s2", 4'hB, 7'h12, 1'b0, 1'b0);
    observe(f * 32 + 3 * 8 + 4);
    check_out("notear_s3", 4'h7, 7'h06, 1'b1, 1'b0);
    observe((f + 1) * 32 + 4);
    check_out("newA_s0", 4'hE, 7'h08, 1'b1, 1'b0);
    observe((f + 1) * 32 + 3 * 8 + 2);
    check_out("newA_s3", 4'h7, 7'h08, 1'b1, 1'b0);

    // Earlier pending 1111, then a load exactly on the boundary cycle with 5555.
    g = k / 32 + 1;
    advance_to(g * 32 + 5);
    do_load(16'h1111, 4'hF, 4'b0000, q);
    observe(g * 32 + 2 * 8 + 2);
    check_out("pend_hidden", 4'hB, 7'h08, 1'b1, 1'b0);
    advance_to(g * 32 + 31);
    do_load(16'h5555, 4'hF, 4'b0000, q);
    observe((g + 1) * 32 + 4);
    check_out("bnd_s0", 4'hE, 7'h24, 1'b1, 1'b0);
    observe((g + 1) * 32 + 2 * 8 + 6);
    check_out("bnd_s2", 4'hB, 7'h24, 1'b1, 1'b0);
    observe((g + 2) * 32 + 8 + 3);
    check_out("bnd_next", 4'hD, 7'h24, 1'b1, 1'b0);

    // Reset while slot 3 is lit: outputs blank on the next clock, active content cleared.
    h = k / 32 + 1;
    advance_to(h * 32 + 3 * 8 + 5);
    check_out("pre_rst", 4'h7, 7'h24, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    check_out("mid_rst", 4'hF, 7'h7F, 1'b1, 1'b0);
    rst = 1'b0;
    k = 0;
    tick();
    check_out("post_rst0", 4'hF, 7'h7F, 1'b1, 1'b1);
    observe(11);
    check_out("post_rst_s1", 4'hF, 7'h7F, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
